relu_maxpool: RTL and testbench
===============================

RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 SHALL have parameter DW, default 16: sample width, two's-complement signed.
REQ-002 SHALL have parameter M, default 8: convolution output map width and height, even, >= 2.
REQ-003 SHALL have port clk  input  1  clock; all flops rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ce  input  1  clock enable, shared with the upstream convolver.
REQ-006 SHALL have port clr  input  1  synchronous frame restart.
REQ-007 SHALL have port in_data  input  DW  convolver output sample.
REQ-008 SHALL have port in_valid  input  1  in_data is a valid convolution result.
REQ-009 SHALL have port out_data  output  DW  pooled result, non-negative.
REQ-010 SHALL have port out_valid  output  1  one-cycle strobe qualifying out_data.
REQ-011 SHALL have port out_done  output  1  sticky; frame of (M/2)*(M/2) results complete.

Function
REQ-012 SHALL accept a sample on any clk edge where ce=1, in_valid=1, clr=0 and out_done=0; otherwise the sample is ignored.
REQ-013 SHALL apply ReLU to each accepted sample: r = 0 if in_data[DW-1]=1, else in_data.
REQ-014 SHALL track accepted samples in raster order with counters col and row, each 0..M-1; col wraps M-1 -> 0 and increments row.
REQ-015 SHALL, on an accepted sample with even col, store r in a hold register.
REQ-016 SHALL, on an accepted sample with odd col, form pm = max(hold, r) using a signed compare.
REQ-017 SHALL, for odd col on even row, write pm into a line buffer of depth M/2 at index col>>1.
REQ-018 SHALL, for odd col on odd row, register out_data = max(linebuf[col>>1], pm) and assert out_valid.
REQ-019 SHALL make out_valid 1 for exactly the clk cycle after the qualifying accept, and 0 on every other cycle, regardless of ce.
REQ-020 SHALL hold out_data unchanged between strobes.
REQ-021 SHALL have a latency of 1 clk from the accept of sample (odd row, odd col) to out_valid.
REQ-022 SHALL set out_done in the same cycle as the out_valid for row=M-1, col=M-1.
REQ-023 SHALL keep out_done set until clr or rst, and stop accepting samples while it is set.
REQ-024 SHALL have out_done high and out_valid low on every cycle after frame end until clr.
REQ-025 SHALL, with ce=0, freeze col, row, hold, line buffer and out_done.
REQ-026 SHALL give clr priority over a same-cycle sample; that sample is dropped.
REQ-027 SHALL have clr zero col, row, hold and out_done, and force out_valid to 0 next cycle.
REQ-028 SHALL leave out_data and the line buffer contents unchanged on clr; line buffer entries are always overwritten before being read.
REQ-029 SHALL produce exactly (M/2)*(M/2) strobes per frame, in raster order of pooled positions.
REQ-030 SHALL tolerate gaps of any length (in_valid=0 or ce=0) between samples with no change in results.

Reset
REQ-031 SHALL, on rst assertion, immediately clear out_data, out_valid, out_done, col, row and hold to 0.
REQ-032 SHALL, when rst is asserted mid-frame, discard the partial frame; the next accepted sample after release is (row 0, col 0).
REQ-033 SHALL not require a reset for the line buffer.

Verification
REQ-034 SHALL pass this scenario: M=4, samples 0..15 back-to-back -> strobes 5, 7, 13, 15; out_done set with the last strobe.
REQ-035 SHALL pass this scenario: M=4, all samples -3 (0xFFFD) -> four strobes of 0.
REQ-036 SHALL pass this scenario: M=4, sample 15 at row 1 col 1 and a gap of 10 cycles with in_valid=0 mid-row 1 -> first strobe 15, same values as gap-free; 16 further samples after done -> no strobes.
REQ-037 SHALL pass this scenario: M=4, ramp 0..15, ce=0 for 3 cycles while in_valid=1 after sample 6 -> held samples not consumed; outputs 5, 7, 13, 15.
REQ-038 SHALL pass this scenario: M=4, clr asserted after 9 samples, then ramp 0..15 -> outputs 5, 7, 13, 15; no strobe from the aborted frame beyond 5 and 7.
REQ-039 SHALL pass this scenario: M=4, rst pulsed asynchronously mid-row 2 -> all outputs 0 at once; fresh ramp gives 5, 7, 13, 15.

Source files
------------

// File: rtl/relu_maxpool.sv
// relu_maxpool: ReLU followed by 2x2 max pooling over a raster-ordered MxM map
module relu_maxpool #(
    parameter int DW = 16,
    parameter int M  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          clr,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_done
);
    localparam int CW = $clog2(M);
    localparam int IW = (M > 2) ? $clog2(M / 2) : 1;
    logic [CW-1:0] col, row;
    logic [DW-1:0] hold, r, pm, pool;
    logic [DW-1:0] lb [M/2];
    logic          acc, col_end, row_end;
    logic [IW-1:0] idx;
    // Accept qualification, ReLU and the two max stages
    always_comb begin
        acc     = ce && in_valid && !clr && !out_done;
        col_end = col == CW'(M - 1);
        row_end = row == CW'(M - 1);
        idx     = IW'(col >> 1);
        r       = in_data[DW-1] ? '0 : in_data;
        pm      = ($signed(hold) > $signed(r)) ? hold : r;
        pool    = ($signed(lb[idx]) > $signed(pm)) ? lb[idx] : pm;
    end
    // Raster counters, horizontal hold, output register and sticky done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_done  <= 1'b0;
        end else begin
            out_valid <= acc && col[0] && row[0];
            if (clr) begin
                col      <= '0;
                row      <= '0;
                hold     <= '0;
                out_done <= 1'b0;
            end else if (acc) begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end)
                    row <= row_end ? '0 : row + 1'b1;
                if (!col[0])
                    hold <= r;
                if (col[0] && row[0]) begin
                    out_data <= pool;
                    if (col_end && row_end)
                        out_done <= 1'b1;
                end
            end
        end
    end
    // Line buffer of horizontal maxima from even rows; always written before read
    always_ff @(posedge clk) begin
        if (acc && col[0] && !row[0])
            lb[idx] <= pm;
    end
endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: directed checks of relu_maxpool with M=4
module tb_relu_maxpool;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_done;
    int          errors = 0;
    int          checks = 0;
    int          sq[$];
    int          dq[$];

    relu_maxpool #(.DW(16), .M(4)) dut (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_done(out_done)
    );

    always #5 clk = ~clk;

    // Strobe recorder: captures pooled values and the done flag seen with each
    always @(negedge clk) begin
        if (out_valid) begin
            sq.push_back(int'(out_data));
            dq.push_back(int'(out_done));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] v);
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic ramp();
        for (int i = 0; i < 16; i++) send(16'(i));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        idle(1);
        sq.delete();
        dq.delete();
    endtask

    task automatic expect4(input string tag, input int a, input int b, input int c, input int d);
        check({tag, "_count"}, sq.size(), 4);
        check({tag, "_s0"}, sq[0], a);
        check({tag, "_s1"}, sq[1], b);
        check({tag, "_s2"}, sq[2], c);
        check({tag, "_s3"}, sq[3], d);
    endtask

    initial begin
        idle(2);
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", out_done, 0);
        rst = 1'b0;
        idle(1);

        ramp();
        idle(2);
        expect4("ramp", 5, 7, 13, 15);
        check("ramp_done_early", dq[2], 0);
        check("ramp_done_last", dq[3], 1);
        check("ramp_done_sticky", out_done, 1);
        check("ramp_valid_idle", out_valid, 0);
        check("ramp_data_hold", out_data, 15);

        restart();
        check("clr_done", out_done, 0);
        for (int i = 0; i < 16; i++) send(16'hFFFD);
        idle(2);
        expect4("neg", 0, 0, 0, 0);

        restart();
        for (int i = 1; i <= 5; i++) send(16'(i));
        send(16'd15);
        idle(10);
        send(16'd6);
        send(16'd7);
        for (int i = 8; i < 16; i++) send(16'(i));
        idle(2);
        expect4("gap", 15, 7, 13, 15);
        for (int i = 0; i < 16; i++) send(16'd100);
        idle(2);
        check("after_done_count", sq.size(), 4);
        check("after_done_flag", out_done, 1);
        check("after_done_data", out_data, 15);

        restart();
        for (int i = 0; i < 7; i++) send(16'(i));
        ce = 1'b0;
        in_data = 16'h7FFF;
        in_valid = 1'b1;
        idle(3);
        ce = 1'b1;
        in_valid = 1'b0;
        for (int i = 7; i < 16; i++) send(16'(i));
        idle(2);
        expect4("ce", 5, 7, 13, 15);

        restart();
        for (int i = 0; i < 9; i++) send(16'(i));
        clr = 1'b1;
        in_data = 16'h7FFF;
        in_valid = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr_valid", out_valid, 0);
        ramp();
        idle(2);
        check("abort_count", sq.size(), 6);
        check("abort_s0", sq[0], 5);
        check("abort_s1", sq[1], 7);
        check("abort_s2", sq[2], 5);
        check("abort_s3", sq[3], 7);
        check("abort_s4", sq[4], 13);
        check("abort_s5", sq[5], 15);

        restart();
        for (int i = 0; i < 9; i++) send(16'(i));
        #2 rst = 1'b1;
        #1;
        check("arst_data", out_data, 0);
        check("arst_valid", out_valid, 0);
        check("arst_done", out_done, 0);
        @(negedge clk);
        rst = 1'b0;
        sq.delete();
        dq.delete();
        ramp();
        idle(2);
        expect4("arst", 5, 7, 13, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
